// File: rtl/cc_depuncture_pkg.sv
`default_nettype none
// ============================================================================
//  Module : p_cc_rate (package)
//  Brief  : Convolutional-code rate codes, puncturing periods and X/Y keep
//           masks shared by the puncturer and the depuncturer.
//  Rev    : 1.0  initial release
// ============================================================================
package p_cc_rate;

    localparam int W      = 2;  // rate-code width
    localparam int KW     = 3;  // pair-index width (k <= 4)
    localparam int MASK_W = 5;  // longest puncturing period

    typedef enum logic [W-1:0] {
        CC_R12 = 2'd0,
        CC_R23 = 2'd1,
        CC_R34 = 2'd2,
        CC_R56 = 2'd3
    } cc_rate_e;

    typedef enum logic {
        NEED_X = 1'b0,
        NEED_Y = 1'b1
    } dp_state_e;

    // Number of (X,Y) pairs in one puncturing period.
    function automatic logic [KW-1:0] cc_period(input logic [W-1:0] rate);
        case (rate)
            CC_R12:  cc_period = 3'd1;
            CC_R23:  cc_period = 3'd2;
            CC_R34:  cc_period = 3'd3;
            default: cc_period = 3'd5;
        endcase
    endfunction

    // X keep mask, bit k = pair index k (1 = transmitted).
    function automatic logic [MASK_W-1:0] cc_xmask(input logic [W-1:0] rate);
        case (rate)
            CC_R12:  cc_xmask = 5'b00001;  // X = 1
            CC_R23:  cc_xmask = 5'b00001;  // X = 10
            CC_R34:  cc_xmask = 5'b00101;  // X = 101
            default: cc_xmask = 5'b10101;  // X = 10101
        endcase
    endfunction

    // Y keep mask, bit k = pair index k (1 = transmitted).
    function automatic logic [MASK_W-1:0] cc_ymask(input logic [W-1:0] rate);
        case (rate)
            CC_R12:  cc_ymask = 5'b00001;  // Y = 1
            CC_R23:  cc_ymask = 5'b00011;  // Y = 11
            CC_R34:  cc_ymask = 5'b00011;  // Y = 110
            default: cc_ymask = 5'b01011;  // Y = 11010
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_depuncture_pattern.sv
`default_nettype none
// ============================================================================
//  Module : cc_punct_pattern
//  Brief  : Combinational lookup of the puncturing pattern at pair index k:
//           X kept, Y kept, and whether k is the last index of the period.
//  Rev    : 1.0  initial release
// ============================================================================
module cc_punct_pattern
    import p_cc_rate::*;
(
    input  logic [W-1:0]  i_rate,
    input  logic [KW-1:0] i_k,
    output logic          o_px,
    output logic          o_py,
    output logic          o_last_k
);

    logic [MASK_W-1:0] w_xmask;
    logic [MASK_W-1:0] w_ymask;
    logic [KW-1:0]     w_last_idx;
    logic              w_k_in_range;

    assign w_xmask      = cc_xmask(i_rate);
    assign w_ymask      = cc_ymask(i_rate);
    assign w_last_idx   = cc_period(i_rate) - KW'(1);
    assign w_k_in_range = (i_k < KW'(MASK_W));

    // Out-of-range k never occurs in normal use; treat it as "keep X only".
    assign o_px     = w_k_in_range ? w_xmask[i_k] : 1'b1;
    assign o_py     = w_k_in_range ? w_ymask[i_k] : 1'b0;
    assign o_last_k = (i_k >= w_last_idx);

endmodule
`default_nettype wire

// File: rtl/cc_depuncture.sv
`default_nettype none
// ============================================================================
//  Module : cc_depuncture
//  Brief  : Rebuilds the rate-1/2 (X,Y) soft-bit pair stream from a
//           punctured stream, marking every deleted position as an erasure.
//  Rev    : 1.0  initial release
// ============================================================================
module cc_depuncture
    import p_cc_rate::*;
#(
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active-low
    input  logic [SW-1:0] in_bit,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [W-1:0]  cc_rate,
    output logic [SW-1:0] out_x,
    output logic [SW-1:0] out_y,
    output logic          out_ex,
    output logic          out_ey,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err_pulse
);

    dp_state_e     r_state;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_rate;
    logic [SW-1:0] r_xhold;

    logic [SW-1:0] r_out_x;
    logic [SW-1:0] r_out_y;
    logic          r_out_ex;
    logic          r_out_ey;
    logic          r_out_last;
    logic          r_out_valid;
    logic          r_err;

    logic          w_acc;
    logic [W-1:0]  w_rate_eff;
    logic [KW-1:0] w_k_eff;
    dp_state_e     w_state_eff;
    logic          w_px;
    logic          w_py;
    logic          w_last_k;

    dp_state_e     w_state_nxt;
    logic [KW-1:0] w_k_nxt;
    logic [W-1:0]  w_rate_nxt;
    logic [SW-1:0] w_xhold_nxt;
    logic          w_emit;
    logic [SW-1:0] w_x;
    logic [SW-1:0] w_y;
    logic          w_ex;
    logic          w_ey;
    logic          w_last;
    logic          w_err;

    assign in_ready = !r_out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    // A block start overrides the stored rate, index and state for this bit.
    assign w_rate_eff  = in_first ? cc_rate : r_rate;
    assign w_k_eff     = in_first ? '0      : r_k;
    assign w_state_eff = in_first ? NEED_X  : r_state;

    cc_punct_pattern u_pattern (
        .i_rate   (w_rate_eff),
        .i_k      (w_k_eff),
        .o_px     (w_px),
        .o_py     (w_py),
        .o_last_k (w_last_k)
    );

    // Next-state, pair assembly and error decision for an accepted bit.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_rate_nxt  = r_rate;
        w_xhold_nxt = r_xhold;
        w_emit      = 1'b0;
        w_x         = '0;
        w_y         = '0;
        w_ex        = 1'b0;
        w_ey        = 1'b0;
        w_last      = 1'b0;
        w_err       = 1'b0;

        if (w_acc) begin
            w_rate_nxt  = w_rate_eff;
            w_k_nxt     = w_k_eff;
            w_state_nxt = w_state_eff;
            // A new block while an X is pending throws that X away.
            w_err       = in_first && (r_state == NEED_Y);

            if (w_state_eff == NEED_Y) begin
                w_emit      = 1'b1;
                w_x         = r_xhold;
                w_y         = in_bit;
                w_state_nxt = NEED_X;
            end else if (!w_px) begin
                w_emit = 1'b1;
                w_ex   = 1'b1;
                w_y    = in_bit;
            end else if (!w_py || in_last) begin
                // Block ending where a Y was still owed truncates the pair.
                w_emit = 1'b1;
                w_x    = in_bit;
                w_ey   = 1'b1;
                if (w_py) begin
                    w_err = 1'b1;
                end
            end else begin
                w_xhold_nxt = in_bit;
                w_state_nxt = NEED_Y;
            end

            if (w_emit) begin
                w_k_nxt = w_last_k ? '0 : (w_k_eff + KW'(1));
            end

            if (in_last) begin
                w_last      = 1'b1;
                w_k_nxt     = '0;
                w_state_nxt = NEED_X;
            end
        end
    end

    // Depuncturing state: FSM, pair index, active rate, pending X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= NEED_X;
            r_k     <= '0;
            r_rate  <= '0;
            r_xhold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_rate  <= w_rate_nxt;
            r_xhold <= w_xhold_nxt;
        end
    end

    // Output pair register: load on emit, release when drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_ex    <= 1'b0;
            r_out_ey    <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_emit) begin
                r_out_x     <= w_x;
                r_out_y     <= w_y;
                r_out_ex    <= w_ex;
                r_out_ey    <= w_ey;
                r_out_last  <= w_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_ex    = r_out_ex;
    assign out_ey    = r_out_ey;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign err_pulse = r_err;

endmodule
`default_nettype wire
